// File: rtl/uart_fifo_bridge.sv
// ---------------------------------------------------------------------------
// uart_fifo_bridge
//
// Byte-buffering stage between the polled CPU I/O port and the UART
// transceiver. A TX FIFO takes bytes from the CPU and hands them to the
// transceiver one at a time over the tx_wr / tx_done handshake. An RX FIFO
// captures every byte the transceiver strobes in with rx_done and holds it
// until the CPU pops it. Levels, full/empty and a sticky overrun flag are
// exposed for the polling software.
//
// Parameters:
//   DEPTH_LOG2   each FIFO holds 2**DEPTH_LOG2 bytes (legal 2..8)
//
// Ports:
//   sys_clk      single clock for all logic
//   sys_rst_n    asynchronous active-low reset
//   wr_en        CPU push of wr_data into the TX FIFO
//   wr_data      byte to transmit
//   tx_full      TX FIFO full
//   tx_level     TX FIFO occupancy
//   tx_idle      TX FIFO empty and no byte in flight
//   rd_en        CPU pop of the RX FIFO head
//   rd_data      RX FIFO head (show-ahead), 8'h00 when empty
//   rx_empty     RX FIFO empty
//   rx_level     RX FIFO occupancy
//   rx_overrun   sticky: a received byte was dropped
//   clr_overrun  clears rx_overrun (a simultaneous new overrun wins)
//   tx_data      byte being sent, to the transceiver
//   tx_wr        one-cycle start pulse, to the transceiver
//   tx_done      one-cycle completion pulse, from the transceiver
//   rx_data      received byte, from the transceiver
//   rx_done      one-cycle strobe marking rx_data valid
// ---------------------------------------------------------------------------
module uart_fifo_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  output logic                tx_full,
  output logic [DEPTH_LOG2:0] tx_level,
  output logic                tx_idle,
  input  logic                rd_en,
  output logic [7:0]          rd_data,
  output logic                rx_empty,
  output logic [DEPTH_LOG2:0] rx_level,
  output logic                rx_overrun,
  input  logic                clr_overrun,
  output logic [7:0]          tx_data,
  output logic                tx_wr,
  input  logic                tx_done,
  input  logic [7:0]          rx_data,
  input  logic                rx_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Constants sized to the pointer / level widths.
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LEVEL_ZERO = '0;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  tx_state_t tx_state;
  tx_state_t tx_state_next;

  // -------------------------------------------------------------------------
  // TX FIFO storage and bookkeeping
  // -------------------------------------------------------------------------
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr;
  logic [DEPTH_LOG2-1:0] tx_rd_ptr;
  logic [DEPTH_LOG2:0]   tx_count;
  logic                  tx_push;
  logic                  tx_pop;

  // -------------------------------------------------------------------------
  // RX FIFO storage and bookkeeping
  // -------------------------------------------------------------------------
  logic [7:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr;
  logic [DEPTH_LOG2-1:0] rx_rd_ptr;
  logic [DEPTH_LOG2:0]   rx_count;
  logic                  rx_full;
  logic                  rx_push;
  logic                  rx_pop;
  logic                  rx_drop;

  // -------------------------------------------------------------------------
  // Status derived from registered state
  // -------------------------------------------------------------------------
  assign tx_full  = (tx_count == FULL_LEVEL);
  assign tx_level = tx_count;
  assign tx_idle  = (tx_state == TX_IDLE) && (tx_count == LEVEL_ZERO);

  assign rx_full  = (rx_count == FULL_LEVEL);
  assign rx_empty = (rx_count == LEVEL_ZERO);
  assign rx_level = rx_count;

  // Show-ahead read port; forced to zero when empty so stale slots never leak.
  assign rd_data  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

  // -------------------------------------------------------------------------
  // TX FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // TX FSM: next-state logic. tx_done outside BUSY is a stale pulse and is
  // simply not looked at.
  // -------------------------------------------------------------------------
  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      TX_IDLE: begin
        if (tx_count != LEVEL_ZERO) begin
          tx_state_next = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          tx_state_next = TX_IDLE;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // TX FSM: output logic. The pop request doubles as the start pulse, which
  // is registered so tx_wr and tx_data appear together one cycle later.
  // -------------------------------------------------------------------------
  always_comb begin
    tx_pop = 1'b0;
    case (tx_state)
      TX_IDLE: tx_pop = (tx_count != LEVEL_ZERO);
      TX_BUSY: tx_pop = 1'b0;
      default: tx_pop = 1'b0;
    endcase
  end

  // A push into a full FIFO is still accepted when the FSM pops in the same
  // cycle, since the pop frees the slot being written.
  assign tx_push = wr_en && (!tx_full || tx_pop);

  // -------------------------------------------------------------------------
  // TX datapath: pointers, level, and the registered transceiver outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      tx_wr     <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      if (tx_push) begin
        tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      end
      if (tx_pop) begin
        tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
        tx_data   <= tx_mem[tx_rd_ptr];
      end
      tx_wr <= tx_pop;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + LEVEL_ONE;
        2'b01:   tx_count <= tx_count - LEVEL_ONE;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // TX storage array. Contents are not reset; the pointers define validity.
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // RX push/pop decisions. A pop on a full FIFO makes room for a byte that
  // arrives in the same cycle, so that case is neither dropped nor flagged.
  // -------------------------------------------------------------------------
  assign rx_pop  = rd_en && !rx_empty;
  assign rx_push = rx_done && (!rx_full || rx_pop);
  assign rx_drop = rx_done && rx_full && !rx_pop;

  // -------------------------------------------------------------------------
  // RX datapath: pointers, level and the sticky overrun flag, where a fresh
  // drop takes priority over a clear in the same cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      end
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + LEVEL_ONE;
        2'b01:   rx_count <= rx_count - LEVEL_ONE;
        default: rx_count <= rx_count;
      endcase
      if (rx_drop) begin
        rx_overrun <= 1'b1;
      end else if (clr_overrun) begin
        rx_overrun <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // RX storage array. Contents are not reset; the pointers define validity.
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr] <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo_bridge
//
// Self-checking bench for uart_fifo_bridge. A queue-based reference model
// predicts every output after every clock edge; directed sequences follow the
// test plan and a randomized phase exercises mixed traffic.
// ---------------------------------------------------------------------------
module tb_uart_fifo_bridge;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                sys_clk = 1'b0;
  logic                sys_rst_n = 1'b1;
  logic                wr_en = 1'b0;
  logic [7:0]          wr_data = 8'h00;
  logic                tx_full;
  logic [DEPTH_LOG2:0] tx_level;
  logic                tx_idle;
  logic                rd_en = 1'b0;
  logic [7:0]          rd_data;
  logic                rx_empty;
  logic [DEPTH_LOG2:0] rx_level;
  logic                rx_overrun;
  logic                clr_overrun = 1'b0;
  logic [7:0]          tx_data;
  logic                tx_wr;
  logic                tx_done = 1'b0;
  logic [7:0]          rx_data = 8'h00;
  logic                rx_done = 1'b0;

  always #5 sys_clk = ~sys_clk;

  uart_fifo_bridge #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .tx_full     (tx_full),
    .tx_level    (tx_level),
    .tx_idle     (tx_idle),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rx_empty    (rx_empty),
    .rx_level    (rx_level),
    .rx_overrun  (rx_overrun),
    .clr_overrun (clr_overrun),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_done     (tx_done),
    .rx_data     (rx_data),
    .rx_done     (rx_done)
  );

  int check_count = 0;
  int error_count = 0;

  // Reference model state: what the spec says is queued, in flight, latched.
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] sent_log[$];
  bit         m_busy;
  bit         m_tx_wr;
  logic [7:0] m_tx_data;
  bit         m_overrun;

  // Transceiver stand-in: returns tx_done a fixed delay after each start.
  bit auto_done = 1'b0;
  int done_cnt  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    tx_q.delete();
    rx_q.delete();
    m_busy    = 1'b0;
    m_tx_wr   = 1'b0;
    m_tx_data = 8'h00;
    m_overrun = 1'b0;
    done_cnt  = 0;
  endtask

  // One clock edge of the bridge as the spec describes it in words.
  task automatic modelEdge(input bit w_en, input logic [7:0] w_data, input bit r_en,
                           input bit r_done, input logic [7:0] r_data, input bit clr,
                           input bit t_done);
    bit         start_tx;
    bit         push_ok;
    bit         was_full;
    bit         popped;
    bit         dropped;
    logic [7:0] scratch;
    start_tx = !m_busy && (tx_q.size() > 0);
    push_ok  = w_en && ((tx_q.size() < DEPTH) || start_tx);
    m_tx_wr  = start_tx;
    if (start_tx) begin
      m_tx_data = tx_q.pop_front();
      m_busy    = 1'b1;
    end else if (m_busy && t_done) begin
      m_busy = 1'b0;
    end
    if (push_ok) tx_q.push_back(w_data);

    was_full = (rx_q.size() == DEPTH);
    popped   = r_en && (rx_q.size() > 0);
    dropped  = 1'b0;
    if (popped) scratch = rx_q.pop_front();
    if (r_done) begin
      if (!was_full || popped) rx_q.push_back(r_data);
      else dropped = 1'b1;
    end
    if (dropped) m_overrun = 1'b1;
    else if (clr) m_overrun = 1'b0;
  endtask

  task automatic checkAll();
    checkOutput("tx_full",    32'(tx_full),    32'(tx_q.size() == DEPTH));
    checkOutput("tx_level",   32'(tx_level),   32'(tx_q.size()));
    checkOutput("tx_idle",    32'(tx_idle),    32'(!m_busy && tx_q.size() == 0));
    checkOutput("tx_wr",      32'(tx_wr),      32'(m_tx_wr));
    checkOutput("tx_data",    32'(tx_data),    32'(m_tx_data));
    checkOutput("rx_empty",   32'(rx_empty),   32'(rx_q.size() == 0));
    checkOutput("rx_level",   32'(rx_level),   32'(rx_q.size()));
    checkOutput("rd_data",    32'(rd_data),    32'((rx_q.size() > 0) ? rx_q[0] : 8'h00));
    checkOutput("rx_overrun", 32'(rx_overrun), 32'(m_overrun));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // sample the DUT 1 time unit after the edge.
  task automatic applyStimulus(input bit w_en, input logic [7:0] w_data, input bit r_en,
                               input bit r_done, input logic [7:0] r_data, input bit clr,
                               input bit t_done);
    bit td;
    td = t_done;
    if (auto_done && done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) td = 1'b1;
    end
    wr_en       = w_en;
    wr_data     = w_data;
    rd_en       = r_en;
    rx_done     = r_done;
    rx_data     = r_data;
    clr_overrun = clr;
    tx_done     = td;
    @(posedge sys_clk);
    modelEdge(w_en, w_data, r_en, r_done, r_data, clr, td);
    #1;
    if (tx_wr === 1'b1) sent_log.push_back(tx_data);
    if (m_tx_wr && auto_done) done_cnt = 10;
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0);
  endtask

  // Assert reset mid-cycle, hold it across one edge, release on a falling edge.
  task automatic doReset();
    #3;
    sys_rst_n   = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    rx_done     = 1'b0;
    clr_overrun = 1'b0;
    tx_done     = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(posedge sys_clk);
    #1;
    checkOutput("reset_tx_idle",  32'(tx_idle),  32'd1);
    checkOutput("reset_rd_data",  32'(rd_data),  32'd0);
    checkOutput("reset_tx_data",  32'(tx_data),  32'd0);
    checkOutput("reset_rx_empty", 32'(rx_empty), 32'd1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int drain_budget;
    $display("[TB] start");
    @(posedge sys_clk);
    #1;

    // Reset values
    doReset();

    // Single TX byte with the transceiver never answering
    sent_log.delete();
    applyStimulus(1, 8'hA5, 0, 0, 8'h00, 0, 0);
    checkOutput("single_no_wr_yet", 32'(tx_wr), 32'd0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 0);
    checkOutput("single_wr_pulse", 32'(tx_wr), 32'd1);
    checkOutput("single_tx_data", 32'(tx_data), 32'hA5);
    idleCycles(100);
    checkOutput("single_wr_count", 32'(sent_log.size()), 32'd1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    checkOutput("single_idle_after_done", 32'(tx_idle), 32'd1);

    // TX fill and ordering
    doReset();
    sent_log.delete();
    auto_done = 1'b0;
    for (int i = 0; i < 17; i++) applyStimulus(1, 8'(i), 0, 0, 8'h00, 0, 0);
    checkOutput("fill_full", 32'(tx_full), 32'd1);
    checkOutput("fill_level", 32'(tx_level), 32'd16);
    applyStimulus(1, 8'h55, 0, 0, 8'h00, 0, 0);
    checkOutput("fill_drop_level", 32'(tx_level), 32'd16);
    auto_done = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    drain_budget = 400;
    while (drain_budget > 0 && !(tx_idle === 1'b1 && sent_log.size() >= 17)) begin
      idleCycles(1);
      drain_budget--;
    end
    checkOutput("fill_drained", 32'(tx_idle), 32'd1);
    checkOutput("fill_sent_count", 32'(sent_log.size()), 32'd17);
    for (int i = 0; i < 17 && i < sent_log.size(); i++)
      checkOutput("fill_order", 32'(sent_log[i]), 32'(i));
    auto_done = 1'b0;

    // RX overrun and draining
    doReset();
    for (int i = 0; i < 17; i++) applyStimulus(0, 8'h00, 0, 1, 8'(8'h20 + i), 0, 0);
    checkOutput("ovr_level", 32'(rx_level), 32'd16);
    checkOutput("ovr_flag", 32'(rx_overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("ovr_read", 32'(rd_data), 32'(8'h20 + i));
      applyStimulus(0, 8'h00, 1, 0, 8'h00, 0, 0);
    end
    checkOutput("ovr_empty", 32'(rx_empty), 32'd1);
    checkOutput("ovr_empty_data", 32'(rd_data), 32'd0);
    applyStimulus(0, 8'h00, 1, 0, 8'h00, 0, 0);
    checkOutput("ovr_read_empty_level", 32'(rx_level), 32'd0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 1, 0);
    checkOutput("ovr_cleared", 32'(rx_overrun), 32'd0);

    // Simultaneous events on a full RX FIFO
    for (int i = 0; i < 16; i++) applyStimulus(0, 8'h00, 0, 1, 8'(8'h40 + i), 0, 0);
    applyStimulus(0, 8'h00, 1, 1, 8'h77, 0, 0);
    checkOutput("sim_level", 32'(rx_level), 32'd16);
    checkOutput("sim_no_overrun", 32'(rx_overrun), 32'd0);
    checkOutput("sim_new_head", 32'(rd_data), 32'h41);
    applyStimulus(0, 8'h00, 0, 1, 8'h88, 1, 0);
    checkOutput("sim_set_wins", 32'(rx_overrun), 32'd1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 1, 0);

    // Reset mid-transmission, then a stale tx_done
    doReset();
    sent_log.delete();
    for (int i = 0; i < 6; i++) applyStimulus(1, 8'(8'h60 + i), 0, 0, 8'h00, 0, 0);
    checkOutput("midtx_level", 32'(tx_level), 32'd5);
    doReset();
    sent_log.delete();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0, 1);
    idleCycles(20);
    checkOutput("midtx_no_wr", 32'(sent_log.size()), 32'd0);
    checkOutput("midtx_level_zero", 32'(tx_level), 32'd0);

    // Randomized mixed traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) doReset();
      applyStimulus($urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 9) < 3,
                    $urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 19) == 0,
                    $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

  // Hard stop in case something above stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
